// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the multi-cycle multiply/divide engine.
//   - op encodings presented on muldiv_hilo.op
//   - FSM state encoding
//   - iteration count and counter width
package muldiv_pkg;

  localparam int MULDIV_ITERS = 32;
  localparam int MULDIV_CNT_W = 5;

  typedef enum logic [1:0] {
    OP_MULT = 2'b00,
    OP_DIV  = 2'b01,
    OP_MTHI = 2'b10,
    OP_MTLO = 2'b11
  } muldivOp_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } muldivState_e;

endpackage

// File: rtl/muldiv_hilo_cond_neg.sv
// cond_neg: conditional two's-complement negate, out = neg ? -in : in.
// Ports:
//   in   [W-1:0]  value to pass through or negate
//   neg           1 = negate
//   out  [W-1:0]  result
module cond_neg #(
  parameter int W = 32
) (
  input  logic [W-1:0] in,
  input  logic         neg,
  output logic [W-1:0] out
);

  assign out = neg ? (~in + W'(1)) : in;

endmodule

// File: rtl/muldiv_hilo.sv
// muldiv_hilo: multi-cycle multiply/divide engine owning the HI/LO registers.
// MULT is shift-add and DIV is restoring division, both one bit per cycle on
// operand magnitudes, with the result signs applied in a fixup step.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start, op       request (sampled when busy=0) and operation select
//   is_signed       two's-complement operands for MULT/DIV
//   a, b            operands (a is also the MTHI/MTLO source)
//   busy            operation in flight (stall source)
//   done            one-cycle pulse when MULT/DIV updates HI/LO
//   hi, lo          architectural HI/LO registers
//   dbz             divide-by-zero pulse (only with MULDIV_DBZ_EN)
// Build option: define MULDIV_DBZ_EN to short-circuit DIV by zero in one
// cycle and raise dbz; otherwise it runs the full algorithm.
module muldiv_hilo
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef MULDIV_DBZ_EN
  ,
  output logic             dbz
`endif
);

  localparam int W2 = 2 * WIDTH;
  localparam logic [MULDIV_CNT_W-1:0] LAST_ITER = MULDIV_CNT_W'(MULDIV_ITERS - 1);

  muldivState_e            state;
  logic [MULDIV_CNT_W-1:0] cnt;
  logic                    fixStage;
  logic                    dbzPend;

  logic [W2-1:0]    acc;
  logic [WIDTH-1:0] bReg;
  logic             isDiv, negRes, negRem;
  logic [WIDTH-1:0] fixHi, fixLo;

  logic sa, sb, accept, dbzHit, startCalc;
  logic [WIDTH-1:0] aMag, bMag;

  assign sa = is_signed & a[WIDTH-1];
  assign sb = is_signed & b[WIDTH-1];

  assign accept = (state == ST_IDLE) && start && !busy &&
                  ((op == OP_MULT) || (op == OP_DIV));
`ifdef MULDIV_DBZ_EN
  assign dbzHit = (op == OP_DIV) && (b == '0);
`else
  assign dbzHit = 1'b0;
`endif
  assign startCalc = accept && !dbzHit;

  cond_neg #(.W(WIDTH)) uNegA (.in(a), .neg(sa), .out(aMag));
  cond_neg #(.W(WIDTH)) uNegB (.in(b), .neg(sb), .out(bMag));

  // Shift-add step: acc = {partial product, unconsumed multiplier bits}.
  logic [WIDTH:0] mulSum;
  logic [W2-1:0]  mulNext;
  assign mulSum  = {1'b0, acc[W2-1:WIDTH]} + {1'b0, (acc[0] ? bReg : '0)};
  assign mulNext = {mulSum, acc[WIDTH-1:1]};

  // Restoring step: acc = {partial remainder, dividend/quotient bits}.
  // The shifted remainder is < 2*divisor, so 33 bits hold the trial.
  logic [W2:0]    divShift;
  logic [WIDTH:0] divTrial;
  logic [W2-1:0]  divNext;
  assign divShift = {acc, 1'b0};
  assign divTrial = divShift[W2:WIDTH] - {1'b0, bReg};
  assign divNext  = divTrial[WIDTH] ? divShift[W2-1:0]
                                    : {divTrial[WIDTH-1:0], divShift[WIDTH-1:1], 1'b1};

  logic [W2-1:0]    prodFix;
  logic [WIDTH-1:0] quoFix, remFix;
  cond_neg #(.W(W2))    uNegProd (.in(acc),              .neg(negRes), .out(prodFix));
  cond_neg #(.W(WIDTH)) uNegQuo  (.in(acc[WIDTH-1:0]),   .neg(negRes), .out(quoFix));
  cond_neg #(.W(WIDTH)) uNegRem  (.in(acc[W2-1:WIDTH]),  .neg(negRem), .out(remFix));

  // ---- control and architectural HI/LO ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      fixStage <= 1'b0;
      dbzPend  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
`ifdef MULDIV_DBZ_EN
      dbz      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef MULDIV_DBZ_EN
      dbz  <= 1'b0;
`endif
      unique case (state)
        ST_IDLE: begin
          if (dbzPend) begin
            dbzPend <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
`ifdef MULDIV_DBZ_EN
            dbz     <= 1'b1;
`endif
          end else if (startCalc) begin
            state <= ST_CALC;
            busy  <= 1'b1;
            cnt   <= '0;
          end else if (accept) begin
            // DIV by zero: one busy cycle, then done+dbz, HI/LO untouched.
            busy    <= 1'b1;
            dbzPend <= 1'b1;
          end else if (start && !busy && (op == OP_MTHI)) begin
            hi <= a;
          end else if (start && !busy && (op == OP_MTLO)) begin
            lo <= a;
          end
        end
        ST_CALC: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_ITER) begin
            state    <= ST_FIX;
            fixStage <= 1'b0;
          end
        end
        ST_FIX: begin
          // First FIX cycle registers the sign-corrected result, second commits.
          if (!fixStage) begin
            fixStage <= 1'b1;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            hi    <= fixHi;
            lo    <= fixLo;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---- iteration datapath ----
  always_ff @(posedge clk) begin
    if (startCalc) begin
      acc    <= {{WIDTH{1'b0}}, aMag};
      bReg   <= bMag;
      isDiv  <= (op == OP_DIV);
      negRes <= sa ^ sb;
      negRem <= sa;
    end else if (state == ST_CALC) begin
      acc <= isDiv ? divNext : mulNext;
    end
    // ---- fixup register ----
    if ((state == ST_FIX) && !fixStage) begin
      fixHi <= isDiv ? remFix : prodFix[W2-1:WIDTH];
      fixLo <= isDiv ? quoFix : prodFix[WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_muldiv_hilo.sv
// tb_muldiv_hilo: self-checking bench for muldiv_hilo. Directed scenarios
// plus randomized operations compared against an arithmetic reference model.
module tb_muldiv_hilo;

  localparam logic [1:0] MULT = 2'b00, DIV = 2'b01, MTHI = 2'b10, MTLO = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n, start, is_signed;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;
`ifdef MULDIV_DBZ_EN
  logic        dbz;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] mHi, mLo;  // reference HI/LO

  always #5 clk = ~clk;

  muldiv_hilo #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .is_signed(is_signed),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
`ifdef MULDIV_DBZ_EN
    , .dbz(dbz)
`endif
  );

  // Reference: result of an operation from plain arithmetic.
  function automatic void model(input logic [1:0] o, input bit s,
                                input logic [31:0] av, input logic [31:0] bv,
                                input logic [31:0] oh, input logic [31:0] ol,
                                output logic [31:0] nh, output logic [31:0] nl,
                                output int lat);
    logic [63:0] p;
    longint x, y, q, r;
    nh = oh; nl = ol; lat = 34;
    case (o)
      MULT: begin
        if (s) p = 64'($signed({{32{av[31]}}, av}) * $signed({{32{bv[31]}}, bv}));
        else   p = {32'b0, av} * {32'b0, bv};
        nh = p[63:32]; nl = p[31:0];
      end
      DIV: begin
        if (bv == 0) begin
`ifdef MULDIV_DBZ_EN
          lat = 1;
`else
          // Magnitude quotient is all ones, remainder is |a|; signs then applied.
          nh = av;
          nl = (s && av[31]) ? 32'h1 : 32'hFFFF_FFFF;
`endif
        end else if (s) begin
          x = longint'($signed(av)); y = longint'($signed(bv));
          q = x / y; r = x % y;
          nl = 32'(q); nh = 32'(r);
        end else begin
          nl = av / bv; nh = av % bv;
        end
      end
      MTHI: begin nh = av; lat = 0; end
      default: begin nl = av; lat = 0; end
    endcase
  endfunction

  // Issue a MULT/DIV and watch until done (bounded).
  task automatic run_op(input logic [1:0] o, input bit s, input logic [31:0] av,
                        input logic [31:0] bv, output int busyCyc,
                        output bit gotDone, output bit doneBusy);
    op = o; is_signed = s; a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    busyCyc = 0; gotDone = 1'b0; doneBusy = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin gotDone = 1'b1; doneBusy = busy; break; end
      if (busy === 1'b1) busyCyc++;
    end
  endtask

  // Issue an MTHI/MTLO; returns #1 after the write edge.
  task automatic do_mt(input logic [1:0] o, input logic [31:0] av);
    op = o; a = av; b = $urandom; is_signed = 1'($urandom); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; op = MULT; is_signed = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    total++; if (hi !== 32'h0)  begin bad++; $display("FAIL reset_hi got=%h exp=0", hi); end
    total++; if (lo !== 32'h0)  begin bad++; $display("FAIL reset_lo got=%h exp=0", lo); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
`ifdef MULDIV_DBZ_EN
    total++; if (dbz !== 1'b0)  begin bad++; $display("FAIL reset_dbz got=%b exp=0", dbz); end
`endif
    rst_n = 1'b1;
    mHi = '0; mLo = '0;
    @(negedge clk);
  endtask

  task automatic test_mult_timing;
    int bc, lat; bit gd, db;
    model(MULT, 1'b0, 32'hFFFF_FFFF, 32'd2, mHi, mLo, mHi, mLo, lat);
    run_op(MULT, 1'b0, 32'hFFFF_FFFF, 32'd2, bc, gd, db);
    total++; if (!gd)         begin bad++; $display("FAIL mult_done_seen got=0 exp=1"); end
    total++; if (bc != 34)    begin bad++; $display("FAIL mult_busy_cycles got=%0d exp=34", bc); end
    total++; if (db !== 1'b0) begin bad++; $display("FAIL mult_busy_at_done got=%b exp=0", db); end
    total++; if (hi !== 32'h1 || hi !== mHi) begin bad++; $display("FAIL mult_hi got=%h exp=00000001", hi); end
    total++; if (lo !== 32'hFFFF_FFFE || lo !== mLo) begin bad++; $display("FAIL mult_lo got=%h exp=fffffffe", lo); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL done_width got=%b exp=0", done); end
  endtask

  task automatic test_directed;
    int bc, lat; bit gd, db;
    logic [1:0]  ops [4] = '{MULT, DIV, DIV, DIV};
    bit          sg  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] av  [4] = '{32'hFFFF_FFFD, 32'd100, 32'hFFFF_FFF9, 32'h8000_0000};
    logic [31:0] bv  [4] = '{32'd5, 32'd7, 32'd2, 32'hFFFF_FFFF};
    logic [31:0] eh  [4] = '{32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'h0};
    logic [31:0] el  [4] = '{32'hFFFF_FFF1, 32'd14, 32'hFFFF_FFFD, 32'h8000_0000};
    for (int i = 0; i < 4; i++) begin
      model(ops[i], sg[i], av[i], bv[i], mHi, mLo, mHi, mLo, lat);
      run_op(ops[i], sg[i], av[i], bv[i], bc, gd, db);
      total++; if (!gd || bc != 34) begin bad++; $display("FAIL directed%0d_timing done=%b busy_cycles=%0d exp 1/34", i, gd, bc); end
      total++; if (hi !== eh[i] || hi !== mHi) begin bad++; $display("FAIL directed%0d_hi got=%h exp=%h", i, hi, eh[i]); end
      total++; if (lo !== el[i] || lo !== mLo) begin bad++; $display("FAIL directed%0d_lo got=%h exp=%h", i, lo, el[i]); end
    end
  endtask

  task automatic test_mthi_mtlo;
    @(negedge clk);
    do_mt(MTHI, 32'h1234_5678);
    op = MTLO; a = 32'h9ABC_DEF0; start = 1'b1;
    total++; if (hi !== 32'h1234_5678) begin bad++; $display("FAIL mthi got=%h exp=12345678", hi); end
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL mthi_flags busy=%b done=%b exp 0/0", busy, done); end
    @(posedge clk); #1;
    start = 1'b0;
    total++; if (lo !== 32'h9ABC_DEF0) begin bad++; $display("FAIL mtlo got=%h exp=9abcdef0", lo); end
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL mtlo_flags busy=%b done=%b exp 0/0", busy, done); end
    mHi = 32'h1234_5678; mLo = 32'h9ABC_DEF0;
    @(negedge clk);
  endtask

  task automatic test_ignored_start;
    int lat; bit gd;
    model(DIV, 1'b0, 32'd1000, 32'd3, mHi, mLo, mHi, mLo, lat);
    op = DIV; is_signed = 1'b0; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(negedge clk);
    op = MTHI; a = 32'hDEAD_BEEF; start = 1'b1;
    @(negedge clk);
    op = MULT; a = 32'd9; b = 32'd9;
    @(negedge clk); start = 1'b0;
    gd = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin gd = 1'b1; break; end
    end
    total++; if (!gd) begin bad++; $display("FAIL ignored_done got=0 exp=1"); end
    total++; if (hi !== mHi) begin bad++; $display("FAIL ignored_hi got=%h exp=%h", hi, mHi); end
    total++; if (lo !== mLo) begin bad++; $display("FAIL ignored_lo got=%h exp=%h", lo, mLo); end
  endtask

  task automatic test_reset_mid;
    int bc, lat; bit gd, db, seen;
    do_mt(MTHI, 32'hAAAA_5555); do_mt(MTLO, 32'h5555_AAAA);
    @(negedge clk);
    op = MULT; is_signed = 1'b0; a = 32'd1234; b = 32'd5678; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0; #1;
    total++; if (hi !== 32'h0 || lo !== 32'h0) begin bad++; $display("FAIL midreset_hilo hi=%h lo=%h exp 0/0", hi, lo); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b exp=0", busy); end
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (done === 1'b1) seen = 1'b1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL midreset_no_done got=%b exp=0", seen); end
    mHi = '0; mLo = '0;
    model(MULT, 1'b0, 32'd6, 32'd7, mHi, mLo, mHi, mLo, lat);
    run_op(MULT, 1'b0, 32'd6, 32'd7, bc, gd, db);
    total++; if (!gd || lo !== 32'd42 || hi !== mHi) begin bad++; $display("FAIL post_reset_mult done=%b hi=%h lo=%h exp lo=0000002a", gd, hi, lo); end
  endtask

  task automatic test_dbz;
    int bc, lat; bit gd, db;
    do_mt(MTHI, 32'h0BAD_F00D); do_mt(MTLO, 32'hC0FF_EE00);
    mHi = 32'h0BAD_F00D; mLo = 32'hC0FF_EE00;
    @(negedge clk);
    model(DIV, 1'b0, 32'd5, 32'd0, mHi, mLo, mHi, mLo, lat);
    run_op(DIV, 1'b0, 32'd5, 32'd0, bc, gd, db);
`ifdef MULDIV_DBZ_EN
    total++; if (!gd || bc != 1) begin bad++; $display("FAIL dbz_timing done=%b busy_cycles=%0d exp 1/1", gd, bc); end
    total++; if (dbz !== 1'b1) begin bad++; $display("FAIL dbz_flag got=%b exp=1", dbz); end
    total++; if (hi !== 32'h0BAD_F00D || lo !== 32'hC0FF_EE00) begin bad++; $display("FAIL dbz_hilo hi=%h lo=%h exp unchanged", hi, lo); end
`else
    total++; if (!gd || bc != 34) begin bad++; $display("FAIL dbz_timing done=%b busy_cycles=%0d exp 1/34", gd, bc); end
    total++; if (hi !== 32'd5 || lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL dbz_result hi=%h lo=%h exp 00000005/ffffffff", hi, lo); end
`endif
    total++; if (hi !== mHi || lo !== mLo) begin bad++; $display("FAIL dbz_model hi=%h lo=%h exp %h/%h", hi, lo, mHi, mLo); end
  endtask

  task automatic test_back_to_back;
    int bc, lat; bit gd, db;
    model(MULT, 1'b0, 32'h0001_0000, 32'h0001_0000, mHi, mLo, mHi, mLo, lat);
    run_op(MULT, 1'b0, 32'h0001_0000, 32'h0001_0000, bc, gd, db);
    total++; if (!gd || hi !== mHi || lo !== mLo) begin bad++; $display("FAIL b2b_first hi=%h lo=%h exp %h/%h", hi, lo, mHi, mLo); end
    // Second start is driven during the done cycle.
    model(DIV, 1'b1, 32'hFFFF_FF00, 32'd16, mHi, mLo, mHi, mLo, lat);
    run_op(DIV, 1'b1, 32'hFFFF_FF00, 32'd16, bc, gd, db);
    total++; if (!gd || bc != 34) begin bad++; $display("FAIL b2b_timing done=%b busy_cycles=%0d exp 1/34", gd, bc); end
    total++; if (hi !== mHi || lo !== mLo) begin bad++; $display("FAIL b2b_second hi=%h lo=%h exp %h/%h", hi, lo, mHi, mLo); end
  endtask

  task automatic test_random;
    int bc, lat; bit gd, db, s;
    logic [1:0] o; logic [31:0] av, bv;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0: o = MTHI;
        1: o = MTLO;
        2, 3, 4, 5: o = MULT;
        default: o = DIV;
      endcase
      s  = 1'($urandom);
      av = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      bv = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      if ($urandom_range(0, 7) == 0) bv = 32'hFFFF_FFFF;
      model(o, s, av, bv, mHi, mLo, mHi, mLo, lat);
      if (lat == 0) begin
        do_mt(o, av);
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rand%0d_mt_flags busy=%b done=%b", n, busy, done); end
        @(negedge clk);
      end else begin
        run_op(o, s, av, bv, bc, gd, db);
        total++; if (!gd || bc != lat) begin bad++; $display("FAIL rand%0d_timing done=%b busy_cycles=%0d exp %0d", n, gd, bc, lat); end
`ifdef MULDIV_DBZ_EN
        total++; if (dbz !== (lat == 1)) begin bad++; $display("FAIL rand%0d_dbz got=%b exp=%b", n, dbz, (lat == 1)); end
`endif
      end
      total++; if (hi !== mHi) begin bad++; $display("FAIL rand%0d_hi op=%0d s=%b a=%h b=%h got=%h exp=%h", n, o, s, av, bv, hi, mHi); end
      total++; if (lo !== mLo) begin bad++; $display("FAIL rand%0d_lo op=%0d s=%b a=%h b=%h got=%h exp=%h", n, o, s, av, bv, lo, mLo); end
    end
  endtask

  initial begin
    test_reset;
    test_mult_timing;
    test_directed;
    test_mthi_mtlo;
    test_ignored_start;
    test_reset_mid;
    test_dbz;
    test_back_to_back;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
